// File: rtl/multicycle_control_unit_if.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit_if
//
// Purpose: groups the signals that pass between the multicycle control unit
// and the datapath it sequences.
//
// Signals:
//   Opcode[5:0]      instruction opcode field (datapath -> control)
//   Zero             ALU zero flag (datapath -> control)
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite     strobes (control -> dp)
//   ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel        select lines
//   PCSrc[1:0]       00 PC+4, 01 branch target, 10 jump target, 11 hold
//   ALUOp[2:0]       000 add, 001 sub, 010 or
//   State[3:0]       current control state
//   Halted           high while in HALT
//   InstrCount[31:0] retired instruction count
//
// Modports:
//   master - datapath side (drives Opcode/Zero)
//   slave  - control unit side (drives strobes, selects and status)
// ----------------------------------------------------------------------------
interface multicycle_control_unit_if;
    logic [5:0]  Opcode;
    logic        Zero;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrcA;
    logic        ALUSrcB;
    logic        RegDst;
    logic        MemToReg;
    logic        ExtSel;
    logic [1:0]  PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  State;
    logic        Halted;
    logic [31:0] InstrCount;

    modport master (
        output Opcode, Zero,
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        input  ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel,
        input  PCSrc, ALUOp, State, Halted, InstrCount
    );

    modport slave (
        input  Opcode, Zero,
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        output ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel,
        output PCSrc, ALUOp, State, Halted, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose: FSM controller for a multicycle MIPS-like datapath. Sequences
// IF -> ID -> EXE -> (MEM) -> (WB) for each instruction, produces all
// datapath strobes/selects combinationally from the current state and the
// opcode, and counts retired instructions (one per PCWrite pulse).
//
// Ports:
//   CLK    - clock, all state updates on the rising edge
//   Reset  - synchronous active-high reset (returns to IF, clears counter)
//   bus    - multicycle_control_unit_if.slave: Opcode/Zero in, control out
//
// Configuration:
//   MULTICYCLE_JUMP_EN - when defined, opcode 111000 (j) is decoded as a
//                        two-cycle jump. When undefined it is an undecoded
//                        opcode and sends the machine to HALT.
// ----------------------------------------------------------------------------
module multicycle_control_unit (
    input  logic                          CLK,
    input  logic                          Reset,
    multicycle_control_unit_if.slave      bus
);

    typedef enum logic [3:0] {
        ST_IF     = 4'b0000,
        ST_ID     = 4'b0001,
        ST_EXE_LS = 4'b0010,
        ST_MEM    = 4'b0011,
        ST_WB_LD  = 4'b0100,
        ST_EXE_BR = 4'b0101,
        ST_EXE_AL = 4'b0110,
        ST_WB_AL  = 4'b0111,
        ST_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    state_t      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic is_add, is_sub, is_addi, is_ori, is_sw, is_lw, is_beq, is_j;
    logic is_alu, is_ls;

    assign is_add  = (bus.Opcode == OP_ADD);
    assign is_sub  = (bus.Opcode == OP_SUB);
    assign is_addi = (bus.Opcode == OP_ADDI);
    assign is_ori  = (bus.Opcode == OP_ORI);
    assign is_sw   = (bus.Opcode == OP_SW);
    assign is_lw   = (bus.Opcode == OP_LW);
    assign is_beq  = (bus.Opcode == OP_BEQ);
`ifdef MULTICYCLE_JUMP_EN
    assign is_j    = (bus.Opcode == OP_J);
`else
    // Without the jump feature 111000 falls through to the undecoded path.
    assign is_j    = 1'b0;
`endif
    assign is_alu  = is_add | is_sub | is_addi | is_ori;
    assign is_ls   = is_lw | is_sw;

    // ------------------------------------------------------------------
    // State register and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= ST_IF;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. halt and undecoded opcodes both end in HALT.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IF:     state_d = ST_ID;
            ST_ID: begin
                if (is_alu)      state_d = ST_EXE_AL;
                else if (is_ls)  state_d = ST_EXE_LS;
                else if (is_beq) state_d = ST_EXE_BR;
                else if (is_j)   state_d = ST_IF;
                else             state_d = ST_HALT;
            end
            ST_EXE_AL: state_d = ST_WB_AL;
            ST_EXE_LS: state_d = ST_MEM;
            ST_MEM:    state_d = is_lw ? ST_WB_LD : ST_IF;
            ST_EXE_BR: state_d = ST_IF;
            ST_WB_AL:  state_d = ST_IF;
            ST_WB_LD:  state_d = ST_IF;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Strobes and PCSrc depend on the state; the datapath
    // selects and ALUOp depend only on the opcode so they are already
    // settled when the state that uses them arrives.
    // ------------------------------------------------------------------
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] alu_op;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = PC_HOLD;
        unique case (state_q)
            ST_IF: ir_write = 1'b1;
            ST_ID: begin
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
            end
            ST_MEM: begin
                if (is_lw) begin
                    mem_read = 1'b1;
                end else begin
                    // sw retires here
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = PC_SEQ;
                end
            end
            ST_EXE_BR: begin
                pc_write = 1'b1;
                pc_src   = bus.Zero ? PC_BRANCH : PC_SEQ;
            end
            ST_WB_AL: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = PC_SEQ;
            end
            ST_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_SEQ;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (is_sub || is_beq) alu_op = ALU_SUB;
        else if (is_ori)      alu_op = ALU_OR;
    end

    assign instr_count_d = instr_count_q + {31'd0, pc_write};

    assign bus.PCWrite    = pc_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUOp      = alu_op;
    assign bus.ALUSrcA    = 1'b0;
    assign bus.ALUSrcB    = is_addi | is_ori | is_ls;
    assign bus.RegDst     = is_add | is_sub;
    assign bus.ExtSel     = ~is_ori;
    assign bus.State      = state_q;
    assign bus.Halted     = (state_q == ST_HALT);
    assign bus.InstrCount = instr_count_q;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 SHALL have port Opcode, input, 6 bits: opcode field of the instruction register, stable from ID until the instruction completes.
REQ-004 SHALL have port Zero, input, 1 bit: ALU zero flag, valid in EXE_BR.
REQ-005 SHALL have outputs PCWrite, IRWrite, RegWrite, MemRead, MemWrite, 1 bit each: write/read strobes.
REQ-006 SHALL have outputs ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel, 1 bit each: select lines for the 32-bit two-input selectors and the sign/zero extender (1 = sign-extend).
REQ-007 SHALL have output PCSrc, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = hold.
REQ-008 SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 or.
REQ-009 SHALL have outputs State, 4 bits (current state), Halted, 1 bit, and InstrCount, 32 bits (retired instructions).

Function
REQ-010 SHALL implement the states IF=0000, ID=0001, EXE_AL=0110, EXE_BR=0101, EXE_LS=0010, MEM=0011, WB_AL=0111, WB_LD=0100 and HALT=1000.
REQ-011 SHALL decode the opcodes add=000000, sub=000001, addi=000010, ori=010010, sw=110000, lw=110001, beq=110100, j=111000 and halt=111111.
REQ-012 SHALL make these transitions: IF->ID; ID->EXE_AL for add/sub/addi/ori; ID->EXE_LS for lw/sw; ID->EXE_BR for beq; ID->IF for j; ID->HALT for halt or any undecoded opcode; EXE_AL->WB_AL; EXE_LS->MEM; MEM->WB_LD for lw, MEM->IF for sw; EXE_BR->IF; WB_AL->IF; WB_LD->IF; HALT->HALT.
REQ-013 SHALL give these instruction latencies in cycles: j 2, beq 3, add/sub/addi/ori 4, sw 4, lw 5.
REQ-014 SHALL assert IRWrite only in IF.
REQ-015 SHALL assert PCWrite for exactly one cycle per instruction, in its final state: WB_AL, WB_LD, MEM for sw, EXE_BR, or ID for j.
REQ-016 SHALL drive PCSrc 01 in EXE_BR when Zero=1, 00 in EXE_BR when Zero=0, 10 in ID for j, 00 in every other final state, and 11 otherwise.
REQ-017 SHALL assert RegWrite only in WB_AL and WB_LD, MemRead only in MEM for lw, and MemWrite only in MEM for sw.
REQ-018 SHALL set RegDst=1 for add/sub and 0 otherwise, and MemToReg=1 only in WB_LD.
REQ-019 SHALL set ALUSrcB=1 for addi/ori/lw/sw and 0 otherwise, and hold ALUSrcA=0 for all listed opcodes.
REQ-020 SHALL set ExtSel=0 for ori and 1 otherwise.
REQ-021 SHALL drive ALUOp 001 for sub/beq, 010 for ori, and 000 otherwise.
REQ-022 SHALL derive all outputs combinationally from State and Opcode; Zero SHALL affect only PCSrc, and only in EXE_BR.
REQ-023 SHALL increment InstrCount by 1 on every cycle in which PCWrite=1, wrapping from 0xFFFFFFFF to 0.
REQ-024 SHALL, in HALT, assert Halted=1, hold PCSrc=11, and keep every strobe at 0 until Reset.

Reset
REQ-025 SHALL, while Reset=1 at a CLK edge, load State=IF and InstrCount=0 regardless of current state, including mid-instruction and HALT.
REQ-026 SHALL, after reset, drive IF outputs: IRWrite=1, PCWrite=0, RegWrite=0, MemRead=0, MemWrite=0, PCSrc=11, ALUOp=000, Halted=0.
REQ-027 SHALL give Reset priority over every transition and over the InstrCount increment in the same cycle.

Configuration
REQ-028 SHALL, when macro MULTICYCLE_JUMP_EN is defined, decode j as in REQ-012/REQ-016.
REQ-029 SHALL, without MULTICYCLE_JUMP_EN, treat opcode 111000 as undecoded (ID->HALT), never drive PCSrc=10, and otherwise behave identically.

Verification
REQ-030 Bench SHALL cover: Reset=1 for 2 cycles then release -> State=0000, IRWrite=1, InstrCount=0.
REQ-031 Bench SHALL cover: Opcode=000000 held -> states 0000,0001,0110,0111,0000; RegWrite=1 and PCWrite=1 only in 0111; InstrCount=1.
REQ-032 Bench SHALL cover: Opcode=110001 -> 5-cycle path with MemRead=1 in 0011 and MemToReg=1, RegWrite=1 in 0100; then Opcode=110000 -> MemWrite=1 in 0011, next state 0000.
REQ-033 Bench SHALL cover: Opcode=110100 with Zero=1 -> PCSrc=01 in 0101; repeat with Zero=0 -> PCSrc=00; both 3 cycles long.
REQ-034 Bench SHALL cover: Opcode=111111 -> HALT reached, Halted=1, InstrCount frozen for 20 cycles; Reset=1 asserted while in 0011 -> State=0000 next cycle.
REQ-035 Bench SHALL cover: Opcode=111000 with and without MULTICYCLE_JUMP_EN -> with: 2-cycle instruction, PCSrc=10; without: HALT.
